prewish5k_mask_sequencer: RTL and testbench

Upstream feeder for the blinky stage. Holds a small table of 8-bit blink masks written over a Wishbone-subset student port. When running, it steps through the table and presents each mask to the blinky's STB_I/DAT_I input as a one-cycle strobe with data, one entry per dwell period. The result is a sequence of blink patterns with no CPU involvement after setup.

---
 rtl/prewish5k_mask_sequencer_pkg.sv | 26 ++
 rtl/prewish5k_dwell_timer.sv | 37 +++
 rtl/prewish5k_mask_sequencer.sv | 174 +++++++++++++++++
 tb/tb_prewish5k_mask_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prewish5k_mask_sequencer_pkg.sv
// Shared definitions for the mask sequencer: register map, CTRL/STATUS bit
// positions and sequencer state encodings.
package prewish5k_mask_sequencer_pkg;

   localparam int unsigned ADR_W  = 4;
   localparam int unsigned DATA_W = 8;

   // Register map
   localparam logic [ADR_W-1:0] ADDR_TABLE_BASE = 4'h0;
   localparam logic [ADR_W-1:0] ADDR_CTRL       = 4'h8;
   localparam logic [ADR_W-1:0] ADDR_STATUS     = 4'h9;

   // CTRL / STATUS bit positions
   localparam int unsigned CTRL_RUN       = 0;
   localparam int unsigned CTRL_LAST_LSB  = 4;
   localparam int unsigned CTRL_LAST_MSB  = 6;
   localparam int unsigned STATUS_RUNNING = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DWELL = 2'd2,
      ST_STOP  = 2'd3
   } state_e;

endpackage

// File: rtl/prewish5k_dwell_timer.sv
// Free-running dwell counter with synchronous clear and count enable.
// Ports: clk_i/rst_ni clock and async active-low reset; clear_i zeroes the
// count; enable_i advances it; term_c_o is a combinational one-cycle pulse
// while enabled at terminal count (all ones).
module prewish5k_dwell_timer #(
   parameter int unsigned DWELL_BITS = 25
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic enable_i,
   output logic term_c_o
);

   logic [DWELL_BITS-1:0] cnt_q, cnt_d;

   // Next count: clear has priority, natural wrap at all ones
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i) begin
         cnt_d = cnt_q + DWELL_BITS'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign term_c_o = enable_i & ~clear_i & (&cnt_q);

endmodule

// File: rtl/prewish5k_mask_sequencer.sv
// Blink-mask sequencer: an 8-entry mask table plus CTRL/STATUS registers on
// a Wishbone-subset slave port; when RUN is set it strobes one table entry
// per dwell period into the downstream blinky.
// Ports: CLK_I/RST_I clock and async active-low reset; CYC_I/STB_I/WE_I/
// ADR_I/DAT_I bus request; DAT_O/ACK_O registered bus response; o_stb/o_dat
// load strobe and mask to the blinky; o_index table index being shown.
module prewish5k_mask_sequencer
   import prewish5k_mask_sequencer_pkg::*;
#(
   parameter int unsigned DEPTH_BITS = 3,
   parameter int unsigned DWELL_BITS = 25
) (
   input  logic                  CLK_I,
   input  logic                  RST_I,
   input  logic                  CYC_I,
   input  logic                  STB_I,
   input  logic                  WE_I,
   input  logic [ADR_W-1:0]      ADR_I,
   input  logic [DATA_W-1:0]     DAT_I,
   output logic [DATA_W-1:0]     DAT_O,
   output logic                  ACK_O,
   output logic                  o_stb,
   output logic [DATA_W-1:0]     o_dat,
   output logic [DEPTH_BITS-1:0] o_index
);

   localparam int unsigned DEPTH = 1 << DEPTH_BITS;

   logic [DATA_W-1:0]     table_q [DEPTH];
   logic                  ack_q;
   logic [DATA_W-1:0]     dat_o_q;
   logic                  run_q;
   logic [DEPTH_BITS-1:0] last_q;

   state_e                state_q, state_d;
   logic                  stb_q, stb_d;
   logic [DATA_W-1:0]     dat_q, dat_d;
   logic [DEPTH_BITS-1:0] idx_q, idx_d;

   logic                  bus_acc_c;
   logic                  tbl_hit_c;
   logic [DEPTH_BITS-1:0] adr_idx_c;
   logic [DATA_W-1:0]     rd_data_c;
   logic [DEPTH_BITS-1:0] idx_nxt_c;
   logic                  tmr_clear_c, tmr_en_c, tmr_term_c;

   // A new access is accepted only when the previous one is not being acked
   assign bus_acc_c = CYC_I & STB_I & ~ack_q;
   assign tbl_hit_c = (ADR_I & ~ADR_W'(DEPTH - 1)) == ADDR_TABLE_BASE;
   assign adr_idx_c = ADR_I[DEPTH_BITS-1:0];

   // Read data mux; unmapped addresses return zero
   always_comb begin
      rd_data_c = '0;
      if (tbl_hit_c) begin
         rd_data_c = table_q[adr_idx_c];
      end else if (ADR_I == ADDR_CTRL) begin
         rd_data_c = (DATA_W'(run_q) << CTRL_RUN) | (DATA_W'(last_q) << CTRL_LAST_LSB);
      end else if (ADR_I == ADDR_STATUS) begin
         rd_data_c = DATA_W'(idx_q) | (DATA_W'(state_q != ST_IDLE) << STATUS_RUNNING);
      end
   end

   // Bus slave registers: table, CTRL, ack and read data
   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         ack_q   <= 1'b0;
         dat_o_q <= '0;
         run_q   <= 1'b0;
         last_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            table_q[i] <= '0;
         end
      end else begin
         ack_q <= bus_acc_c;
         if (bus_acc_c) begin
            dat_o_q <= rd_data_c;
            if (WE_I) begin
               if (tbl_hit_c) begin
                  table_q[adr_idx_c] <= DAT_I;
               end else if (ADR_I == ADDR_CTRL) begin
                  run_q  <= DAT_I[CTRL_RUN];
                  last_q <= DEPTH_BITS'(DAT_I[CTRL_LAST_MSB:CTRL_LAST_LSB]);
               end
            end
         end
      end
   end

   // Advance wraps whenever the index is at or beyond LAST, so a lowered LAST takes effect at once
   assign idx_nxt_c   = (idx_q >= last_q) ? '0 : idx_q + DEPTH_BITS'(1);
   assign tmr_clear_c = (state_q == ST_LOAD);
   assign tmr_en_c    = (state_q == ST_DWELL);

   prewish5k_dwell_timer #(
      .DWELL_BITS(DWELL_BITS)
   ) u_dwell_timer (
      .clk_i    (CLK_I),
      .rst_ni   (RST_I),
      .clear_i  (tmr_clear_c),
      .enable_i (tmr_en_c),
      .term_c_o (tmr_term_c)
   );

   // Sequencer next state; o_stb/o_dat/o_index are loaded on the transition
   // so the strobe is high during the LOAD (or STOP) cycle itself
   always_comb begin
      state_d = state_q;
      stb_d   = 1'b0;
      dat_d   = dat_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (run_q) begin
               state_d = ST_LOAD;
               stb_d   = 1'b1;
               idx_d   = '0;
               dat_d   = table_q[0];
            end
         end
         ST_LOAD: begin
            state_d = run_q ? ST_DWELL : ST_STOP;
         end
         ST_DWELL: begin
            // Stop outranks a coincident terminal count
            if (!run_q) begin
               state_d = ST_STOP;
               stb_d   = 1'b1;
               dat_d   = '0;
               idx_d   = '0;
            end else if (tmr_term_c) begin
               state_d = ST_LOAD;
               stb_d   = 1'b1;
               idx_d   = idx_nxt_c;
               dat_d   = table_q[idx_nxt_c];
            end
         end
         ST_STOP: begin
            // Entered from LOAD the blank is deferred a cycle to keep strobes apart
            if (stb_q) begin
               state_d = ST_IDLE;
            end else begin
               stb_d = 1'b1;
               dat_d = '0;
               idx_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         state_q <= ST_IDLE;
         stb_q   <= 1'b0;
         dat_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         stb_q   <= stb_d;
         dat_q   <= dat_d;
         idx_q   <= idx_d;
      end
   end

   assign ACK_O   = ack_q;
   assign DAT_O   = dat_o_q;
   assign o_stb   = stb_q;
   assign o_dat   = dat_q;
   assign o_index = idx_q;

endmodule

// File: tb/tb_prewish5k_mask_sequencer.sv
// Scoreboard bench for prewish5k_mask_sequencer with a 16-clock dwell.
module tb_prewish5k_mask_sequencer;

   logic       clk   = 1'b0;
   logic       RST_I = 1'b1;
   logic       CYC_I = 1'b0;
   logic       STB_I = 1'b0;
   logic       WE_I  = 1'b0;
   logic [3:0] ADR_I = 4'h0;
   logic [7:0] DAT_I = 8'h00;
   logic [7:0] DAT_O;
   logic       ACK_O;
   logic       o_stb;
   logic [7:0] o_dat;
   logic [2:0] o_index;

   prewish5k_mask_sequencer #(
      .DEPTH_BITS(3),
      .DWELL_BITS(4)
   ) dut (
      .CLK_I   (clk),
      .RST_I   (RST_I),
      .CYC_I   (CYC_I),
      .STB_I   (STB_I),
      .WE_I    (WE_I),
      .ADR_I   (ADR_I),
      .DAT_I   (DAT_I),
      .DAT_O   (DAT_O),
      .ACK_O   (ACK_O),
      .o_stb   (o_stb),
      .o_dat   (o_dat),
      .o_index (o_index)
   );

   always #5 clk = ~clk;

   typedef struct { logic [7:0] dat; logic [2:0] idx; int cyc; } stb_exp_t;
   typedef struct { bit chk; logic [7:0] dat; } bus_exp_t;

   stb_exp_t   sq[$];
   bus_exp_t   bq[$];
   int         n_chk = 0;
   int         n_fail = 0;
   int         ncyc = 0;
   logic       prev_ack = 1'b0;
   logic       prev_stb = 1'b0;
   logic [7:0] hold_dat = 8'h00;
   logic [2:0] hold_idx = 3'd0;
   stb_exp_t   se;
   bus_exp_t   be;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, ncyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT acks or strobes
   always @(negedge clk) begin
      ncyc++;
      if (!RST_I) begin
         prev_ack = 1'b0;
         prev_stb = 1'b0;
         hold_dat = 8'h00;
         hold_idx = 3'd0;
      end else begin
         if (ACK_O) begin
            check("ack_single", 32'(prev_ack), 0);
            if (bq.size() == 0) begin
               check("ack_expected", 1, 0);
            end else begin
               be = bq.pop_front();
               if (be.chk) check("dat_o", 32'(DAT_O), 32'(be.dat));
            end
         end
         if (o_stb) begin
            check("stb_apart", 32'(prev_stb), 0);
            if (sq.size() == 0) begin
               check("stb_expected", 1, 0);
            end else begin
               se = sq.pop_front();
               check("o_dat", 32'(o_dat), 32'(se.dat));
               check("o_index", 32'(o_index), 32'(se.idx));
               check("stb_cycle", ncyc, se.cyc);
            end
            hold_dat = o_dat;
            hold_idx = o_index;
         end else begin
            check("o_dat_hold", 32'(o_dat), 32'(hold_dat));
            check("o_index_hold", 32'(o_index), 32'(hold_idx));
         end
         prev_ack = ACK_O;
         prev_stb = o_stb;
      end
   end

   // One bus access; t is the monitor cycle number in which it is sampled
   task automatic bus(input bit we, input logic [3:0] adr, input logic [7:0] dat,
                      input logic [7:0] exp_rd, output int t);
      bus_exp_t e;
      e.chk = !we;
      e.dat = exp_rd;
      bq.push_back(e);
      @(negedge clk);
      #1;
      CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = dat;
      t = ncyc;
      @(posedge clk);
      #1;
      CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
      @(posedge clk);
   endtask

   task automatic wr(input logic [3:0] adr, input logic [7:0] dat);
      int t;
      bus(1'b1, adr, dat, 8'h00, t);
   endtask

   task automatic rd(input logic [3:0] adr, input logic [7:0] exp);
      int t;
      bus(1'b0, adr, 8'h00, exp, t);
   endtask

   task automatic push_stb(input logic [7:0] dat, input logic [2:0] idx, input int cyc);
      stb_exp_t e;
      e.dat = dat;
      e.idx = idx;
      e.cyc = cyc;
      sq.push_back(e);
   endtask

   task automatic wait_until(input int c);
      while (ncyc < c) begin
         @(negedge clk);
         #2;
      end
   endtask

   task automatic wait_drain(input int limit);
      int n = 0;
      while ((sq.size() != 0 || bq.size() != 0) && n < limit) begin
         @(negedge clk);
         #2;
         n++;
      end
      check("drain_pending", sq.size() + bq.size(), 0);
   endtask

   task automatic check_reset_outputs();
      check("rst_ack", 32'(ACK_O), 0);
      check("rst_dat_o", 32'(DAT_O), 0);
      check("rst_o_stb", 32'(o_stb), 0);
      check("rst_o_dat", 32'(o_dat), 0);
      check("rst_o_index", 32'(o_index), 0);
   endtask

   initial begin
      int t0, t2, tw;
      // Power-on reset mid-cycle
      #2 RST_I = 1'b0;
      #1 check_reset_outputs();
      repeat (2) @(negedge clk);
      #1 RST_I = 1'b1;

      for (int a = 0; a < 8; a++) rd(4'(a), 8'h00);
      rd(4'h8, 8'h00);
      rd(4'h9, 8'h00);

      // Basic bus behaviour
      wr(4'h3, 8'hA0);
      rd(4'h3, 8'hA0);
      rd(4'hC, 8'h00);
      wr(4'hC, 8'hFF);
      rd(4'hC, 8'h00);

      // Three-entry sequence, LAST = 2
      wr(4'h0, 8'hF0);
      wr(4'h1, 8'hAA);
      wr(4'h2, 8'h81);
      bus(1'b1, 4'h8, 8'h21, 8'h00, t0);
      push_stb(8'hF0, 3'd0, t0 + 2);
      push_stb(8'hAA, 3'd1, t0 + 19);
      push_stb(8'h81, 3'd2, t0 + 36);
      push_stb(8'hF0, 3'd0, t0 + 53);
      push_stb(8'hAA, 3'd1, t0 + 70);
      push_stb(8'h81, 3'd2, t0 + 87);
      push_stb(8'h55, 3'd0, t0 + 104);

      // Live edit of the displayed entry 0
      wait_until(t0 + 53);
      wr(4'h0, 8'h55);
      rd(4'h0, 8'h55);

      // Clear RUN so it lands in the terminal-count cycle after the t0+104 strobe
      wait_until(t0 + 118);
      bus(1'b1, 4'h8, 8'h20, 8'h00, tw);
      push_stb(8'h00, 3'd0, t0 + 121);
      wait_drain(40);
      rd(4'h9, 8'h00);
      rd(4'h8, 8'h20);

      // LAST shrink from index 2, then LAST = 0 with RUN rewritten while running
      bus(1'b1, 4'h8, 8'h31, 8'h00, t2);
      push_stb(8'h55, 3'd0, t2 + 2);
      push_stb(8'hAA, 3'd1, t2 + 19);
      push_stb(8'h81, 3'd2, t2 + 36);
      push_stb(8'h55, 3'd0, t2 + 53);
      wait_until(t2 + 36);
      wr(4'h8, 8'h11);
      wait_until(t2 + 53);
      wr(4'h8, 8'h01);
      push_stb(8'h55, 3'd0, t2 + 70);
      push_stb(8'h55, 3'd0, t2 + 87);
      rd(4'h9, 8'h80);
      wait_until(t2 + 90);
      wait_drain(20);

      // Reset mid-dwell: immediate clear, no blank strobe
      @(posedge clk);
      #3 RST_I = 1'b0;
      #1 check_reset_outputs();
      repeat (2) @(negedge clk);
      #1 RST_I = 1'b1;
      for (int a = 0; a < 8; a++) rd(4'(a), 8'h00);
      rd(4'h8, 8'h00);
      rd(4'h9, 8'h00);
      repeat (40) @(negedge clk);
      wait_drain(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
